alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Stage directly downstream of the alert latch. Consumes the latched alert level (q) and drives
//  an annunciator: a pulsed buzzer, a steady lamp, and escalation after a set number of unanswered beeps.
//  On operator acknowledge, pulses alert_clr. This pulse drives the alert latch's rst to clear it.
//  The block then re-arms itself if the alert persists.
// PARAMETERS
//  BEEP_ON_CYC   4   buzzer-high cycles per beep (>=1)
//  BEEP_OFF_CYC  4   buzzer-low cycles between beeps (>=1)
//  ESC_BEEPS     3   completed beeps before escalation (>=1)
//  CLEAR_CYC     2   alert_clr pulse length in cycles (>=1)
//  TMR_W         16  timer width; must hold max(BEEP_ON_CYC,BEEP_OFF_CYC,CLEAR_CYC)-1
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  alert_q    in   1          latched alert level from upstream alert latch (q)
//  ack        in   1          operator acknowledge, level, sampled each clk
//  buzzer     out  1          annunciator drive
//  lamp       out  1          1 whenever an alarm is active or being cleared
//  escalate   out  1          1 in ESCALATED state
//  alert_clr  out  1          clear pulse to upstream latch rst
//  beep_cnt   out  CW         completed beeps, CW=$clog2(ESC_BEEPS+1)
// BEHAVIOUR
//  - rst high at a clk edge: state=IDLE, timer=0, beep_cnt=0. All outputs 0 next cycle.
//    Reset overrides everything else, including mid-beep, mid-escalation and mid-clear.
//  - Outputs are decoded from registered state only. There is no input-to-output combinational path.
//    Latency is exactly 1 cycle from input sample to output change.
//  - Timer: loaded with N-1 on state entry and decremented each cycle. The state exits when timer==0.
//    A state with length N is therefore held exactly N cycles.
//  - States and outputs (buzzer/lamp/escalate/alert_clr):
//    IDLE      0/0/0/0   alert_q=1 -> BEEP_ON, beep_cnt=0
//    BEEP_ON   1/1/0/0   timer==0 -> BEEP_OFF, beep_cnt+1 (saturates at ESC_BEEPS)
//    BEEP_OFF  0/1/0/0   timer==0 -> ESCALATED if beep_cnt==ESC_BEEPS, else BEEP_ON
//    ESCALATED 1/1/1/0   buzzer held continuously; leaves only on ack or rst
//    CLEARING  0/1/0/1   timer==0 -> BEEP_ON (beep_cnt=0) if alert_q==1, else IDLE
//  - ack=1 in BEEP_ON, BEEP_OFF or ESCALATED -> CLEARING, timer=CLEAR_CYC-1, beep_cnt held.
//    ack takes priority over a same-cycle timer expiry.
//  - ack is ignored in IDLE and in CLEARING. Holding ack high does not extend the clear pulse.
//  - alert_q dropping to 0 outside IDLE/CLEARING is ignored. The sequence continues until ack.
//  - alert_q is evaluated in CLEARING only on the final cycle, when timer==0.
//    If upstream re-latched during the pulse, the sequence restarts.
//  - beep_cnt resets to 0 on entry to BEEP_ON from IDLE or CLEARING. It never wraps.
//  - Encoding: 3-bit binary state. Unused encodings go to IDLE on the next edge.
// STRUCTURE
//  - Shared package alarm_pkg holds: state localparams (ST_IDLE..ST_CLEARING), STATE_W=3,
//    and the CW width function. The bench uses these for state checks.
//  - One sub-module, alarm_timer: TMR_W down-counter with load, load value, enable and zero flag.
//    It is reused for all three timed states.
//  - Top level holds the FSM, beep counter and output decode.
// TESTING (defaults unless noted; cycle 0 = first edge sampling alert_q=1)
//  1. Reset mid-BEEP_ON (rst=1 for 1 cycle) -> next cycle all outputs 0, beep_cnt=0, state IDLE.
//  2. alert_q=1, no ack -> buzzer high cycles 1-4 and low 5-8, three beeps.
//     escalate=1 and buzzer held high from cycle 25; beep_cnt=3.
//  3. ack=1 at cycle 6 (BEEP_OFF), alert_q falls after clear ->
//     alert_clr=1 cycles 7-8, lamp=1, buzzer=0, then IDLE at cycle 9 with lamp=0.
//  4. ack on the same edge as BEEP_ON timer expiry (cycle 4) -> CLEARING at cycle 5 (not BEEP_OFF).
//     beep_cnt stays 0.
//  5. alert_q held 1 through CLEARING -> BEEP_ON immediately after the 2-cycle pulse, beep_cnt=0.
//  6. ack in IDLE, and ack held 10 cycles in CLEARING -> no state change in IDLE.
//     alert_clr is exactly CLEAR_CYC=2 cycles.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm annunciator.
// State encoding and beep counter width.
package alarm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_BEEP_ON   = 3'd1,
    ST_BEEP_OFF  = 3'd2,
    ST_ESCALATED = 3'd3,
    ST_CLEARING  = 3'd4
  } state_e;

  function automatic int cw(input int esc_beeps);
    return $clog2(esc_beeps + 1);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Down-counter shared by every timed state.
// Load wins over decrement; counting stops at zero.
module alarm_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // next count: load, else decrement toward zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Annunciator sequencer behind the alert latch.
// Beeps, escalates, and pulses a latch clear on ack.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int BEEP_ON_CYC  = 4,
  parameter int BEEP_OFF_CYC = 4,
  parameter int ESC_BEEPS    = 3,
  parameter int CLEAR_CYC    = 2,
  parameter int TMR_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alert_q,
  input  logic                     ack,
  output logic                     buzzer,
  output logic                     lamp,
  output logic                     escalate,
  output logic                     alert_clr,
  output logic [cw(ESC_BEEPS)-1:0] beep_cnt
);

  localparam int CW = cw(ESC_BEEPS);

  localparam logic [TMR_W-1:0] ON_LD  = TMR_W'(BEEP_ON_CYC - 1);
  localparam logic [TMR_W-1:0] OFF_LD = TMR_W'(BEEP_OFF_CYC - 1);
  localparam logic [TMR_W-1:0] CLR_LD = TMR_W'(CLEAR_CYC - 1);
  localparam logic [CW-1:0]    ESC_N  = CW'(ESC_BEEPS);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            t_load;
  logic [TMR_W-1:0] t_val;
  logic            t_en;
  logic            t_zero;

  alarm_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  // next state, beep count and timer control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alert_q) begin
          state_d = ST_BEEP_ON;
          cnt_d   = '0;
          t_load  = 1'b1;
          t_val   = ON_LD;
        end
      end
      ST_BEEP_ON: begin
        if (ack) begin
          state_d = ST_CLEARING;
          t_load  = 1'b1;
          t_val   = CLR_LD;
        end else if (t_zero) begin
          state_d = ST_BEEP_OFF;
          t_load  = 1'b1;
          t_val   = OFF_LD;
          if (cnt_q != ESC_N) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          t_en = 1'b1;
        end
      end
      ST_BEEP_OFF: begin
        if (ack) begin
          state_d = ST_CLEARING;
          t_load  = 1'b1;
          t_val   = CLR_LD;
        end else if (t_zero) begin
          if (cnt_q == ESC_N) begin
            state_d = ST_ESCALATED;
          end else begin
            state_d = ST_BEEP_ON;
            t_load  = 1'b1;
            t_val   = ON_LD;
          end
        end else begin
          t_en = 1'b1;
        end
      end
      ST_ESCALATED: begin
        if (ack) begin
          state_d = ST_CLEARING;
          t_load  = 1'b1;
          t_val   = CLR_LD;
        end
      end
      ST_CLEARING: begin
        if (t_zero) begin
          if (alert_q) begin
            state_d = ST_BEEP_ON;
            cnt_d   = '0;
            t_load  = 1'b1;
            t_val   = ON_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          t_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and beep count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    buzzer    = 1'b0;
    lamp      = 1'b0;
    escalate  = 1'b0;
    alert_clr = 1'b0;
    case (state_q)
      ST_BEEP_ON: begin
        buzzer = 1'b1;
        lamp   = 1'b1;
      end
      ST_BEEP_OFF: begin
        lamp = 1'b1;
      end
      ST_ESCALATED: begin
        buzzer   = 1'b1;
        lamp     = 1'b1;
        escalate = 1'b1;
      end
      ST_CLEARING: begin
        lamp      = 1'b1;
        alert_clr = 1'b1;
      end
      default: begin
        buzzer = 1'b0;
      end
    endcase
  end

  assign beep_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer.
// Reference model works in elapsed-time terms.
module tb_alarm_sequencer;
  import alarm_pkg::*;

  localparam int ON  = 4;
  localparam int OFF = 4;
  localparam int ESC = 3;
  localparam int CLR = 2;
  localparam int P   = ON + OFF;
  localparam int CW  = cw(ESC);
  localparam int VW  = STATE_W + 4 + CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alert_q = 1'b0;
  logic ack = 1'b0;
  logic buzzer, lamp, escalate, alert_clr;
  logic [CW-1:0] beep_cnt;

  alarm_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .alert_q   (alert_q),
    .ack       (ack),
    .buzzer    (buzzer),
    .lamp      (lamp),
    .escalate  (escalate),
    .alert_clr (alert_clr),
    .beep_cnt  (beep_cnt)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 beeping, 2 escalated, 3 clearing
  int mode = 0;
  int t = 0;
  int cc = 0;
  int cnt = 0;

  logic [VW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input logic r, input logic a, input logic k);
    if (r) begin
      mode = 0;
      cnt  = 0;
    end else begin
      case (mode)
        0: if (a) begin
          mode = 1;
          t    = 0;
        end
        1: if (k) begin
          mode = 3;
          cc   = 0;
        end else if (t == ESC * P - 1) begin
          mode = 2;
        end else begin
          t++;
        end
        2: if (k) begin
          mode = 3;
          cc   = 0;
        end
        default: if (cc == CLR - 1) begin
          mode = a ? 1 : 0;
          t    = 0;
        end else begin
          cc++;
        end
      endcase
      if (mode == 1) cnt = imin((t + OFF) / P, ESC);
      if (mode == 2) cnt = ESC;
    end
  endtask

  function automatic logic [VW-1:0] model_out();
    logic [STATE_W-1:0] s;
    logic b, l, e, c;
    s = ST_IDLE;
    b = 0; l = 0; e = 0; c = 0;
    case (mode)
      1: begin
        b = (t % P) < ON;
        l = 1;
        s = b ? ST_BEEP_ON : ST_BEEP_OFF;
      end
      2: begin
        b = 1; l = 1; e = 1;
        s = ST_ESCALATED;
      end
      3: begin
        l = 1; c = 1;
        s = ST_CLEARING;
      end
      default: s = ST_IDLE;
    endcase
    return {s, b, l, e, c, CW'(cnt)};
  endfunction

  task automatic cyc(input logic r, input logic a, input logic k);
    @(negedge clk);
    rst     = r;
    alert_q = a;
    ack     = k;
    model_step(r, a, k);
    exp_q.push_back(model_out());
  endtask

  // monitor: compare each registered response against the scoreboard
  initial begin
    logic [VW-1:0] act, ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex  = exp_q.pop_front();
        act = {dut.state_q, buzzer, lamp, escalate, alert_clr, beep_cnt};
        n_cmp++;
        if (act !== ex) begin
          n_bad++;
          $display("FAIL cyc%0d st/bz/lp/es/cl/cnt got=%b want=%b",
                   n_cmp, act, ex);
        end
      end
    end
  end

  initial begin
    // reset
    repeat (2) cyc(1, 0, 0);
    // reset mid beep
    repeat (3) cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    // full escalation, then ack
    repeat (30) cyc(0, 1, 0);
    cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);
    // ack in BEEP_OFF, alert falls
    repeat (6) cyc(0, 1, 0);
    cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);
    // ack on BEEP_ON expiry
    repeat (4) cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (3) cyc(0, 0, 0);
    // alert held through clearing
    repeat (2) cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (6) cyc(0, 1, 0);
    cyc(1, 0, 0);
    // ack in idle, ack held in clearing
    repeat (3) cyc(0, 0, 1);
    cyc(0, 1, 0);
    repeat (10) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 29) == 0);
    end
    cyc(0, 0, 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
